dio_cfg_sequencer: RTL

Upstream feeder for the digital-I/O controller: buffers host-written configuration words, each paired with a dwell time, and replays them as single-cycle `config_en` strobes with `config_data` held stable, spaced by the programmed dwell. It lets software preload a timed I/O pattern (Hi-Z / drive-low / drive-high / custom) and fire it with one `start` pulse. An `abort` forces the pins to a safe word immediately.

---
 rtl/dio_pkg.sv | 15 +
 rtl/dio_cfg_fifo.sv | 49 ++++
 rtl/dio_cfg_sequencer.sv | 73 +++++++
 3 files changed

// File: rtl/dio_pkg.sv
// dio_pkg: shared constants and types for the DIO configuration sequencer
package dio_pkg;
    localparam logic [1:0] DIO_MODE_HIZ    = 2'b00;
    localparam logic [1:0] DIO_MODE_LOW    = 2'b01;
    localparam logic [1:0] DIO_MODE_HIGH   = 2'b10;
    localparam logic [1:0] DIO_MODE_CUSTOM = 2'b11;
    localparam int DIO_DW = 16;
    localparam int DIO_CW = 16;
    localparam logic [DIO_DW-1:0] DIO_SAFE_WORD = {DIO_MODE_HIZ, 14'h0000};
    typedef enum logic {ST_IDLE, ST_PLAY} state_e;
    typedef struct packed {
        logic [DIO_CW-1:0] dwell;
        logic [DIO_DW-1:0] data;
    } entry_t;
endpackage

// File: rtl/dio_cfg_fifo.sv
// dio_cfg_fifo: show-ahead synchronous FIFO with flush and occupancy count
module dio_cfg_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic [W-1:0]  head
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;
    logic          do_push, do_pop;
    assign full    = lvl_q == LW'(DEPTH);
    assign empty   = lvl_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = lvl_q;
    assign head    = mem_q[rd_q];
    // pointer and occupancy bookkeeping; flush wins over any push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end
    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/dio_cfg_sequencer.sv
// dio_cfg_sequencer: replays queued config words as timed config_en strobes
module dio_cfg_sequencer
    import dio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW = 16,
    parameter int CW = 16,
    parameter logic [DW-1:0] SAFE_WORD = DW'(DIO_SAFE_WORD),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic [CW-1:0] s_dwell,
    output logic          s_ready,
    input  logic          start,
    input  logic          abort,
    output logic          config_en,
    output logic [DW-1:0] config_data,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] level
);
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             en_q, en_d, done_q, done_d;
    logic [DW-1:0]    data_q, data_d;
    logic             full, empty, push, issue, expired;
    logic [CW+DW-1:0] head;
    dio_cfg_fifo #(.DEPTH(DEPTH), .W(CW + DW)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(issue), .flush(abort),
        .din({s_dwell, s_data}), .full(full), .empty(empty), .level(level), .head(head)
    );
    assign s_ready     = !full && !abort && !rst;
    assign push        = s_valid && s_ready;
    assign expired     = state_q == ST_PLAY && cnt_q == '0;
    assign issue       = !abort && !empty && (state_q == ST_IDLE ? start : expired);
    assign busy        = state_q == ST_PLAY;
    assign config_en   = en_q;
    assign config_data = data_q;
    assign done        = done_q;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else state_q <= state_d;
    end
    // next state: abort returns to IDLE, an issue enters PLAY, an expired dwell with nothing queued ends playback
    always_comb begin
        state_d = abort ? ST_IDLE : issue ? ST_PLAY : expired ? ST_IDLE : state_q;
    end
    // output and dwell-counter next values
    always_comb begin
        en_d   = abort || issue;
        data_d = abort ? SAFE_WORD : issue ? head[DW-1:0] : data_q;
        cnt_d  = abort ? '0 : issue ? head[CW+DW-1:DW] : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        done_d = !abort && expired && empty;
    end
    // output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end
endmodule
